// File: rtl/huffman_pkg.sv
// Shared types and helpers for the 6-symbol Huffman decoder.
// Consumers gate the optional decode counters with HUFF_DEC_CNT_EN.
package huffman_pkg;

    localparam int SYM_NUM = 6;
    localparam int CODE_W  = 8;

    typedef struct packed {
        logic [7:0] hc;
        logic [7:0] m;
        logic [3:0] len;
    } code_entry_t;

    typedef enum logic [0:0] {
        EMPTY  = 1'b0,
        DECODE = 1'b1
    } dec_state_e;

    function automatic logic [3:0] popcount8(input logic [7:0] v);
        logic [3:0] c;
        c = '0;
        for (int i = 0; i < 8; i++) c = c + {3'b000, v[i]};
        return c;
    endfunction

endpackage

// File: rtl/huffman_code_match.sv
// Compares the shifted-in code against one table entry; unused entries (len 0) never hit.
module huffman_code_match
    import huffman_pkg::*;
(
    input  code_entry_t         entry,
    input  logic [CODE_W-1:0]   sr_n,
    input  logic [3:0]          len_n,
    output logic                hit
);

    assign hit = (entry.len == len_n) && (entry.len != 4'd0) &&
                 ((sr_n & entry.m) == (entry.hc & entry.m));

endmodule

// File: rtl/huffman_decoder.sv
// Serial MSB-first Huffman decoder for gray symbols 1..6 with a loadable code table.
// Define HUFF_DEC_CNT_EN to add per-symbol decode counters dec_cnt1..dec_cnt6.
module huffman_decoder
    import huffman_pkg::*;
(
    input  logic       clk,
    input  logic       reset,
    input  logic       code_valid,
    input  logic [7:0] HC1,
    input  logic [7:0] HC2,
    input  logic [7:0] HC3,
    input  logic [7:0] HC4,
    input  logic [7:0] HC5,
    input  logic [7:0] HC6,
    input  logic [7:0] M1,
    input  logic [7:0] M2,
    input  logic [7:0] M3,
    input  logic [7:0] M4,
    input  logic [7:0] M5,
    input  logic [7:0] M6,
    input  logic       bit_valid,
    input  logic       bit_in,
    output logic       bit_ready,
    output logic       sym_valid,
    output logic [2:0] sym,
    input  logic       sym_ready,
    output logic       err
`ifdef HUFF_DEC_CNT_EN
    ,
    output logic [7:0] dec_cnt1,
    output logic [7:0] dec_cnt2,
    output logic [7:0] dec_cnt3,
    output logic [7:0] dec_cnt4,
    output logic [7:0] dec_cnt5,
    output logic [7:0] dec_cnt6
`endif
);

    localparam logic [0:0] S_EMPTY  = EMPTY;
    localparam logic [0:0] S_DECODE = DECODE;

    logic [CODE_W-1:0] hc_in [SYM_NUM];
    logic [CODE_W-1:0] m_in  [SYM_NUM];
    code_entry_t       tbl   [SYM_NUM];

    logic [0:0]        state;
    logic [CODE_W-1:0] sr, sr_n;
    logic [3:0]        len, len_n;
    logic [SYM_NUM-1:0] hit;
    logic              any_hit;
    logic [2:0]        hit_idx;
    logic              accept, taken;

    assign hc_in[0] = HC1;  assign m_in[0] = M1;
    assign hc_in[1] = HC2;  assign m_in[1] = M2;
    assign hc_in[2] = HC3;  assign m_in[2] = M3;
    assign hc_in[3] = HC4;  assign m_in[3] = M4;
    assign hc_in[4] = HC5;  assign m_in[4] = M5;
    assign hc_in[5] = HC6;  assign m_in[5] = M6;

    assign bit_ready = (state == S_DECODE) && !(sym_valid && !sym_ready);
    // A table load in the same cycle drops the offered bit.
    assign accept    = bit_valid && bit_ready && !code_valid;
    assign taken     = sym_valid && sym_ready;
    assign sr_n      = {sr[CODE_W-2:0], bit_in};
    assign len_n     = len + 4'd1;

    for (genvar g = 0; g < SYM_NUM; g++) begin : g_match
        huffman_code_match u_match (
            .entry (tbl[g]),
            .sr_n  (sr_n),
            .len_n (len_n),
            .hit   (hit[g])
        );
    end

    // Lowest index wins when a malformed table produces several hits.
    always_comb begin
        hit_idx = '0;
        for (int i = SYM_NUM - 1; i >= 0; i--) begin
            if (hit[i]) hit_idx = 3'(i);
        end
    end
    assign any_hit = |hit;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < SYM_NUM; i++) tbl[i] <= '0;
        end else if (code_valid) begin
            for (int i = 0; i < SYM_NUM; i++) begin
                tbl[i].hc  <= hc_in[i];
                tbl[i].m   <= m_in[i];
                tbl[i].len <= popcount8(m_in[i]);
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state     <= S_EMPTY;
            sr        <= '0;
            len       <= '0;
            sym_valid <= 1'b0;
            sym       <= '0;
            err       <= 1'b0;
        end else begin
            err <= 1'b0;
            if (taken) sym_valid <= 1'b0;
            if (code_valid) begin
                state <= S_DECODE;
                sr    <= '0;
                len   <= '0;
            end else if (accept) begin
                if (any_hit) begin
                    sym_valid <= 1'b1;
                    sym       <= hit_idx + 3'd1;
                    sr        <= '0;
                    len       <= '0;
                end else if (len_n == 4'(CODE_W)) begin
                    err <= 1'b1;
                    sr  <= '0;
                    len <= '0;
                end else begin
                    sr  <= sr_n;
                    len <= len_n;
                end
            end
        end
    end

`ifdef HUFF_DEC_CNT_EN
    logic [SYM_NUM-1:0][7:0] cnt;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt <= '0;
        end else if (code_valid) begin
            cnt <= '0;
        end else if (accept && any_hit) begin
            for (int i = 0; i < SYM_NUM; i++) begin
                if (hit_idx == 3'(i)) cnt[i] <= cnt[i] + 8'd1;
            end
        end
    end

    assign dec_cnt1 = cnt[0];
    assign dec_cnt2 = cnt[1];
    assign dec_cnt3 = cnt[2];
    assign dec_cnt4 = cnt[3];
    assign dec_cnt5 = cnt[4];
    assign dec_cnt6 = cnt[5];
`endif

endmodule

// File: tb/tb_huffman_decoder.sv
// Self-checking bench for huffman_decoder; reference decodes with bit strings and symbol queues.
module tb_huffman_decoder;

    logic       clk = 1'b0;
    logic       reset;
    logic       code_valid;
    logic [7:0] hc [6];
    logic [7:0] m  [6];
    logic       bit_valid, bit_in, bit_ready;
    logic       sym_valid, sym_ready, err;
    logic [2:0] sym;
`ifdef HUFF_DEC_CNT_EN
    logic [7:0] dec_cnt1, dec_cnt2, dec_cnt3, dec_cnt4, dec_cnt5, dec_cnt6;
`endif

    int total = 0;
    int bad   = 0;

    localparam logic [7:0] T_HC [6] = '{8'h01, 8'h01, 8'h01, 8'h01, 8'h01, 8'h00};
    localparam logic [7:0] T_M  [6] = '{8'h01, 8'h03, 8'h07, 8'h0F, 8'h1F, 8'h1F};

    always #5 clk = ~clk;

    huffman_decoder dut (
        .clk(clk), .reset(reset), .code_valid(code_valid),
        .HC1(hc[0]), .HC2(hc[1]), .HC3(hc[2]), .HC4(hc[3]), .HC5(hc[4]), .HC6(hc[5]),
        .M1(m[0]), .M2(m[1]), .M3(m[2]), .M4(m[3]), .M5(m[4]), .M6(m[5]),
        .bit_valid(bit_valid), .bit_in(bit_in), .bit_ready(bit_ready),
        .sym_valid(sym_valid), .sym(sym), .sym_ready(sym_ready), .err(err)
`ifdef HUFF_DEC_CNT_EN
        , .dec_cnt1(dec_cnt1), .dec_cnt2(dec_cnt2), .dec_cnt3(dec_cnt3),
        .dec_cnt4(dec_cnt4), .dec_cnt5(dec_cnt5), .dec_cnt6(dec_cnt6)
`endif
    );

    // Code as transmitted: first char is the first bit on the wire.
    function automatic string code_str(input logic [7:0] h, input logic [7:0] mm);
        string s;
        int    n;
        s = "";
        n = 0;
        for (int i = 0; i < 8; i++) if (mm[i]) n++;
        for (int b = n - 1; b >= 0; b--) s = {s, h[b] ? "1" : "0"};
        return s;
    endfunction

    function automatic int model_match(input string cur);
        for (int i = 0; i < 6; i++) begin
            if (m[i] != 8'h00 && code_str(hc[i], m[i]) == cur) return i + 1;
        end
        return 0;
    endfunction

    task automatic load_t(input logic [5:0] en);
        for (int i = 0; i < 6; i++) begin
            hc[i] = T_HC[i];
            m[i]  = en[i] ? T_M[i] : 8'h00;
        end
        code_valid = 1'b1;
        @(posedge clk); #1;
        code_valid = 1'b0;
    endtask

    task automatic send_bit(input logic b, input logic rdy);
        bit_valid = 1'b1;
        bit_in    = b;
        sym_ready = rdy;
        @(posedge clk); #1;
        bit_valid = 1'b0;
    endtask

    task automatic send_sym(input int s);
        string c;
        c = code_str(hc[s-1], m[s-1]);
        for (int i = 0; i < c.len(); i++) send_bit(c[i] == "1", 1'b1);
    endtask

    task automatic idle();
        sym_ready = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic test_reset();
        reset = 1'b0; code_valid = 1'b0; bit_valid = 1'b0; bit_in = 1'b0; sym_ready = 1'b1;
        for (int i = 0; i < 6; i++) begin hc[i] = 8'h00; m[i] = 8'h00; end
        #12;
        total++; if (sym_valid !== 1'b0) begin bad++; $display("FAIL reset_sym_valid got=%b exp=0", sym_valid); end
        total++; if (sym !== 3'd0) begin bad++; $display("FAIL reset_sym got=%0d exp=0", sym); end
        total++; if (err !== 1'b0) begin bad++; $display("FAIL reset_err got=%b exp=0", err); end
        total++; if (bit_ready !== 1'b0) begin bad++; $display("FAIL reset_bit_ready got=%b exp=0", bit_ready); end
        @(posedge clk); #1;
        reset = 1'b1;
        bit_valid = 1'b1;
        @(posedge clk); #1;
        total++; if (bit_ready !== 1'b0) begin bad++; $display("FAIL empty_bit_ready got=%b exp=0", bit_ready); end
        bit_valid = 1'b0;
    endtask

    task automatic test_basic();
        load_t(6'h3F);
        send_bit(1'b1, 1'b1);
        total++; if (sym_valid !== 1'b1 || sym !== 3'd1) begin bad++; $display("FAIL basic_sym1 got=%b/%0d exp=1/1", sym_valid, sym); end
        send_bit(1'b0, 1'b1);
        total++; if (sym_valid !== 1'b0) begin bad++; $display("FAIL basic_taken got=%b exp=0", sym_valid); end
        send_bit(1'b1, 1'b1);
        total++; if (sym_valid !== 1'b1 || sym !== 3'd2) begin bad++; $display("FAIL basic_sym2 got=%b/%0d exp=1/2", sym_valid, sym); end
        idle();
    endtask

    task automatic test_long_codes();
        logic [9:0] bits;
        bits = 10'b0000000001;
        load_t(6'h3F);
        for (int i = 9; i >= 0; i--) begin
            bit_valid = 1'b1; bit_in = bits[i]; sym_ready = 1'b1;
            #1;
            total++; if (bit_ready !== 1'b1) begin bad++; $display("FAIL long_bit_ready got=%b exp=1 at=%0d", bit_ready, 9 - i); end
            @(posedge clk); #1;
            bit_valid = 1'b0;
            if (i == 5) begin
                total++; if (sym_valid !== 1'b1 || sym !== 3'd6) begin bad++; $display("FAIL long_sym6 got=%b/%0d exp=1/6", sym_valid, sym); end
            end
        end
        total++; if (sym_valid !== 1'b1 || sym !== 3'd5) begin bad++; $display("FAIL long_sym5 got=%b/%0d exp=1/5", sym_valid, sym); end
        idle();
    endtask

    task automatic test_err();
        load_t(6'b000011);
        for (int k = 0; k < 8; k++) begin
            send_bit(1'b0, 1'b1);
            if (k == 6) begin
                total++; if (err !== 1'b0) begin bad++; $display("FAIL err_early got=%b exp=0", err); end
            end
        end
        total++; if (err !== 1'b1) begin bad++; $display("FAIL err_pulse got=%b exp=1", err); end
        total++; if (sym_valid !== 1'b0) begin bad++; $display("FAIL err_no_sym got=%b exp=0", sym_valid); end
        send_bit(1'b1, 1'b1);
        total++; if (err !== 1'b0) begin bad++; $display("FAIL err_one_cycle got=%b exp=0", err); end
        total++; if (sym_valid !== 1'b1 || sym !== 3'd1) begin bad++; $display("FAIL err_recover got=%b/%0d exp=1/1", sym_valid, sym); end
        idle();
    endtask

    task automatic test_backpressure();
        load_t(6'h3F);
        send_bit(1'b1, 1'b0);
        total++; if (sym_valid !== 1'b1 || sym !== 3'd1) begin bad++; $display("FAIL bp_sym got=%b/%0d exp=1/1", sym_valid, sym); end
        bit_valid = 1'b1; bit_in = 1'b0; sym_ready = 1'b0;
        #1;
        total++; if (bit_ready !== 1'b0) begin bad++; $display("FAIL bp_not_ready got=%b exp=0", bit_ready); end
        repeat (2) @(posedge clk);
        #1;
        total++; if (sym_valid !== 1'b1 || sym !== 3'd1) begin bad++; $display("FAIL bp_held got=%b/%0d exp=1/1", sym_valid, sym); end
        bit_valid = 1'b0; sym_ready = 1'b1;
        @(posedge clk); #1;
        total++; if (sym_valid !== 1'b0 || bit_ready !== 1'b1) begin bad++; $display("FAIL bp_release got=%b/%b exp=0/1", sym_valid, bit_ready); end
        send_bit(1'b1, 1'b1);
        total++; if (sym_valid !== 1'b1 || sym !== 3'd1) begin bad++; $display("FAIL bp_dropped_bit got=%b/%0d exp=1/1", sym_valid, sym); end
        idle();
    endtask

    task automatic test_back_to_back();
        load_t(6'h3F);
        send_bit(1'b0, 1'b1);
        send_bit(1'b1, 1'b1);
        total++; if (sym_valid !== 1'b1 || sym !== 3'd2) begin bad++; $display("FAIL b2b_first got=%b/%0d exp=1/2", sym_valid, sym); end
        send_bit(1'b1, 1'b1);
        total++; if (sym_valid !== 1'b1 || sym !== 3'd1) begin bad++; $display("FAIL b2b_second got=%b/%0d exp=1/1", sym_valid, sym); end
        idle();
        total++; if (sym_valid !== 1'b0 || sym !== 3'd1) begin bad++; $display("FAIL b2b_drain got=%b/%0d exp=0/1", sym_valid, sym); end
    endtask

    task automatic test_reload();
        load_t(6'h3F);
        send_bit(1'b0, 1'b1);
        send_bit(1'b0, 1'b1);
        bit_valid = 1'b1; bit_in = 1'b1; code_valid = 1'b1;
        @(posedge clk); #1;
        bit_valid = 1'b0; code_valid = 1'b0;
        total++; if (sym_valid !== 1'b0) begin bad++; $display("FAIL reload_bit_dropped got=%b exp=0", sym_valid); end
        send_bit(1'b1, 1'b1);
        total++; if (sym_valid !== 1'b1 || sym !== 3'd1) begin bad++; $display("FAIL reload_partial_cleared got=%b/%0d exp=1/1", sym_valid, sym); end
        sym_ready = 1'b0;
        send_bit(1'b0, 1'b1);
        send_bit(1'b1, 1'b0);
        load_t(6'h3F);
        total++; if (sym_valid !== 1'b1 || sym !== 3'd2) begin bad++; $display("FAIL reload_pending_kept got=%b/%0d exp=1/2", sym_valid, sym); end
        idle();
    endtask

    task automatic test_random_stream();
        int    exp_q[$];
        int    got_q[$];
        logic  bq[$];
        int    errs, cyc;
        logic  acc;
        string c;
        load_t(6'h3F);
        errs = 0;
        for (int i = 0; i < 40; i++) begin
            exp_q.push_back($urandom_range(1, 6));
            c = code_str(hc[exp_q[i]-1], m[exp_q[i]-1]);
            for (int j = 0; j < c.len(); j++) bq.push_back(c[j] == "1");
        end
        cyc = 0;
        while (got_q.size() < 40 && cyc < 3000) begin
            bit_valid = (bq.size() != 0) && ($urandom_range(0, 3) != 0);
            bit_in    = (bq.size() != 0) ? bq[0] : 1'b0;
            sym_ready = $urandom_range(0, 1) == 1;
            #1;
            acc = bit_valid && bit_ready;
            if (sym_valid && sym_ready) got_q.push_back(int'(sym));
            if (err) errs++;
            @(posedge clk);
            if (acc) void'(bq.pop_front());
            #1;
            cyc++;
        end
        bit_valid = 1'b0;
        total++; if (got_q.size() != 40) begin bad++; $display("FAIL rand_stream_count got=%0d exp=40", got_q.size()); end
        total++; if (errs != 0) begin bad++; $display("FAIL rand_stream_err got=%0d exp=0", errs); end
        for (int i = 0; i < got_q.size(); i++) begin
            total++; if (got_q[i] != exp_q[i]) begin bad++; $display("FAIL rand_stream_sym idx=%0d got=%0d exp=%0d", i, got_q[i], exp_q[i]); end
        end
        idle();
    endtask

    task automatic test_random_bits();
        string cur;
        int    s;
        logic  b, ev, ee;
        for (int r = 0; r < 6; r++) begin
            load_t(6'($urandom_range(1, 63)));
            cur = "";
            for (int k = 0; k < 60; k++) begin
                b = $urandom_range(0, 1) == 1;
                send_bit(b, 1'b1);
                cur = {cur, b ? "1" : "0"};
                s = model_match(cur);
                ev = 1'b0; ee = 1'b0;
                if (s != 0) begin ev = 1'b1; cur = ""; end
                else if (cur.len() == 8) begin ee = 1'b1; cur = ""; end
                total++;
                if (sym_valid !== ev || err !== ee || (ev && sym !== 3'(s))) begin
                    bad++;
                    $display("FAIL rand_bits r=%0d k=%0d got v=%b s=%0d e=%b exp v=%b s=%0d e=%b",
                             r, k, sym_valid, sym, err, ev, s, ee);
                end
            end
        end
        idle();
    endtask

    task automatic test_reset_midcode();
        load_t(6'h3F);
        send_bit(1'b0, 1'b1);
        send_bit(1'b0, 1'b1);
        bit_valid = 1'b1; bit_in = 1'b0;
        #2 reset = 1'b0;
        #1;
        total++; if (sym_valid !== 1'b0 || sym !== 3'd0 || err !== 1'b0 || bit_ready !== 1'b0) begin
            bad++; $display("FAIL midreset_outputs got=%b/%0d/%b/%b exp=0/0/0/0", sym_valid, sym, err, bit_ready);
        end
        @(posedge clk); #1;
        reset = 1'b1; bit_in = 1'b1;
        repeat (3) begin
            @(posedge clk); #1;
            total++; if (bit_ready !== 1'b0 || sym_valid !== 1'b0) begin bad++; $display("FAIL midreset_empty got=%b/%b exp=0/0", bit_ready, sym_valid); end
        end
        bit_valid = 1'b0;
        load_t(6'h3F);
        send_bit(1'b1, 1'b1);
        total++; if (sym_valid !== 1'b1 || sym !== 3'd1) begin bad++; $display("FAIL midreset_reload got=%b/%0d exp=1/1", sym_valid, sym); end
        idle();
    endtask

`ifdef HUFF_DEC_CNT_EN
    task automatic test_counters();
        int seq [4] = '{1, 1, 2, 6};
        int exp_c [6];
        logic [7:0] got [6];
        load_t(6'h3F);
        for (int i = 0; i < 6; i++) exp_c[i] = 0;
        for (int i = 0; i < 4; i++) begin send_sym(seq[i]); exp_c[seq[i]-1]++; end
        idle();
        got = '{dec_cnt1, dec_cnt2, dec_cnt3, dec_cnt4, dec_cnt5, dec_cnt6};
        for (int i = 0; i < 6; i++) begin
            total++; if (got[i] !== 8'(exp_c[i])) begin bad++; $display("FAIL cnt%0d got=%0d exp=%0d", i + 1, got[i], exp_c[i]); end
        end
        load_t(6'h3F);
        got = '{dec_cnt1, dec_cnt2, dec_cnt3, dec_cnt4, dec_cnt5, dec_cnt6};
        for (int i = 0; i < 6; i++) begin
            total++; if (got[i] !== 8'd0) begin bad++; $display("FAIL cnt_clear%0d got=%0d exp=0", i + 1, got[i]); end
        end
    endtask
`endif

    initial begin
        #2_000_000;
        $display("FAIL watchdog total=%0d bad=%0d", total, bad);
        $fatal(1, "timeout");
    end

    initial begin
        test_reset();
        test_basic();
        test_long_codes();
        test_err();
        test_backpressure();
        test_back_to_back();
        test_reload();
        test_random_stream();
        test_random_bits();
`ifdef HUFF_DEC_CNT_EN
        test_counters();
`endif
        test_reset_midcode();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
